jstk_spi_responder: RTL
=======================

// Module: jstk_spi_responder
// PURPOSE
//  SPI slave that emulates the PmodJSTK device. It answers the PmodJSTK master
//  (SS/SCLK/MOSI/MISO) with a 5-byte joystick frame built from local X/Y/button
//  inputs, and decodes the master's command byte into LED outputs.
//  Used as the board-to-board joystick link and as the bench model for the game top.
// PARAMETERS
//  SYNC_STAGES  2      synchroniser depth on SS/SCLK/MOSI (min 2)
//  FRAME_BYTES  5      bytes per full frame; bytes past the 5th return PAD_BYTE
//  PAD_BYTE     8'h00  MISO byte for any byte index >= 5
// PORTS
//  clk          in   1   system clock; SCLK period must be >= 8 clk
//  reset_n      in   1   asynchronous active-low reset
//  ss           in   1   SPI select, active low (async to clk)
//  sclk         in   1   SPI clock, mode 0 (async to clk)
//  mosi         in   1   master data out
//  miso         out  1   slave data; MSB first
//  joy_x        in   10  stick X position, 0..1023
//  joy_y        in   10  stick Y position, 0..1023
//  btn          in   3   {Z, stick, C} buttons, active high
//  led          out  2   LED state from the last accepted command
//  frame_done   out  1   1-clk pulse: SS rose on a byte boundary with >= 1 byte done
//  frame_abort  out  1   1-clk pulse: SS rose mid-byte
//  frame_cnt    out  16  completed frames, saturating (JSTK_RESP_STATS_EN)
//  abort_cnt    out  8   aborted frames, saturating (JSTK_RESP_STATS_EN)
// BEHAVIOUR
//  - Reset: miso=0, led=2'b00, frame_done=0, frame_abort=0, counters=0, FSM=IDLE.
//  - Inputs pass through SYNC_STAGES flops. Edges are detected on the synchronised copies.
//  - FSM IDLE -> LOAD on ss fall.
//    LOAD (1 clk): snapshot joy_x, joy_y and btn into a 40-bit shadow, then -> SHIFT.
//    The snapshot is the only sample taken; inputs changing mid-frame do not affect the frame.
//  - Frame byte order (first sent first):
//    byte0 = Y[7:0]
//    byte1 = {6'b0, Y[9:8]}
//    byte2 = X[7:0]
//    byte3 = {6'b0, X[9:8]}
//    byte4 = {5'b0, btn[2], btn[1], btn[0]}
//    The master's 40-bit DOUT therefore holds Y-low in [39:32] and C in bit 0.
//  - The MSB of byte0 is driven on miso in the LOAD cycle, i.e. <= SYNC_STAGES+1 clk after SS falls.
//  - SHIFT, mode 0:
//    on synchronised sclk rise: sample mosi into rx_shift and increment bit_cnt (3 bits);
//    on sclk fall: present the next tx bit on miso.
//    When bit_cnt wraps 7->0, byte_cnt increments; it saturates at 7, and any byte index >= 5 loads PAD_BYTE.
//  - Command: the first completed rx byte is the command.
//    If cmd[7]=1, led_next = cmd[1:0]; otherwise led is unchanged. Later rx bytes are ignored.
//    led updates only on frame_done, never on abort.
//  - SHIFT -> DONE on ss rise.
//    DONE (1 clk):
//      bit_cnt==0 and byte_cnt>=1 -> frame_done=1, commit led, frame_cnt++;
//      otherwise -> frame_abort=1, abort_cnt++.
//    Then -> IDLE. An SS rise with zero bytes is an abort.
//  - SS fall arriving in the DONE cycle is honoured: next state is LOAD.
//  - SCLK edges while SS is high are ignored. miso holds its last value while idle.
//  - reset_n asserted mid-frame returns everything to reset values at once. After release the
//    current frame is ignored until SS rises and falls again.
// CONFIGURATION
//  JSTK_RESP_STATS_EN defined:
//    frame_cnt and abort_cnt are live saturating counters (hold at 16'hFFFF / 8'hFF).
//  Undefined:
//    both ports drive constant 0 and no counter flops are built. Port list is unchanged.
// STRUCTURE
//  - Shared include jstk_defs.vh:
//    JSTK_FRAME_BYTES=5, JSTK_CMD_LED_BIT=7, byte-index localparams, button bit positions
//    (C=0, STICK=1, Z=2), FSM state encodings. The game top's unpacking uses the same include.
//  - Sub-module spi_edge_sync: parameterised synchroniser plus rise/fall pulse generator,
//    instantiated for ss, sclk and mosi (mosi uses the level only).
// TESTING
//  1. X=10'h2A5, Y=10'h13C, btn=3'b101, master sends 0x80 + 4x 0x00 ->
//     miso bytes 3C,01,A5,02,05; frame_done once; led stays 00.
//  2. Command byte 0x83 in a full frame -> led=2'b11 one clk after the DONE cycle;
//     command 0x03 -> led unchanged.
//  3. Change joy_x from 0 to 1023 after the 2nd byte -> bytes 2/3 still carry the snapshot value 0.
//  4. SS rises after 13 bits -> frame_abort pulse, led unchanged, abort_cnt=1 (STATS_EN).
//  5. 7-byte frame -> bytes 5 and 6 return 0x00, frame_done, frame_cnt +1.
//  6. Assert reset_n low mid-byte2 -> all outputs at reset values. Next full frame returns correct
//     bytes. Back-to-back frames with 1 SCLK-period SS-high gap both complete.

Source files
------------

// File: rtl/jstk_spi_responder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jstk_spi_responder_pkg : shared PmodJSTK frame layout, commands and FSM    |
// | Revision 1.0                                                               |
// +--------------------------------------------------------------------------+
package jstk_spi_responder_pkg;

  localparam int JSTK_FRAME_BYTES = 5;
  localparam int JSTK_CMD_LED_BIT = 7;

  localparam logic [2:0] BYTE_Y_LO = 3'd0;
  localparam logic [2:0] BYTE_Y_HI = 3'd1;
  localparam logic [2:0] BYTE_X_LO = 3'd2;
  localparam logic [2:0] BYTE_X_HI = 3'd3;
  localparam logic [2:0] BYTE_BTN  = 3'd4;

  localparam int BTN_C     = 0;
  localparam int BTN_STICK = 1;
  localparam int BTN_Z     = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // 40-bit frame in transmit order: byte0 occupies [39:32]
  function automatic logic [39:0] jstk_frame(input logic [9:0] x, input logic [9:0] y,
                                             input logic [2:0] b);
    return {y[7:0], 6'b0, y[9:8], x[7:0], 6'b0, x[9:8],
            5'b0, b[BTN_Z], b[BTN_STICK], b[BTN_C]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/jstk_spi_responder_spi_edge_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jstk_spi_responder_spi_edge_sync : N-flop synchroniser with edge pulses    |
// | Revision 1.0                                                               |
// +--------------------------------------------------------------------------+
module jstk_spi_responder_spi_edge_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule
`default_nettype wire

// File: rtl/jstk_spi_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jstk_spi_responder : PmodJSTK SPI slave emulator (JSTK_RESP_STATS_EN opt.) |
// | Revision 1.0                                                               |
// +--------------------------------------------------------------------------+
module jstk_spi_responder
  import jstk_spi_responder_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         FRAME_BYTES = JSTK_FRAME_BYTES,
  parameter logic [7:0] PAD_BYTE    = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ss,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  input  logic [9:0]  joy_x,
  input  logic [9:0]  joy_y,
  input  logic [2:0]  btn,
  output logic [1:0]  led,
  output logic        frame_done,
  output logic        frame_abort,
  output logic [15:0] frame_cnt,
  output logic [7:0]  abort_cnt
);

  logic ss_lvl_unused, ss_rise, ss_fall;
  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  // SS resets low so a frame already in progress at reset release produces no fall
  jstk_spi_responder_spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ss (
    .clk(clk), .rst_ni(reset_n), .d_i(ss),
    .level_o(ss_lvl_unused), .rise_o(ss_rise), .fall_o(ss_fall));

  jstk_spi_responder_spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_ni(reset_n), .d_i(sclk),
    .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall));

  jstk_spi_responder_spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_ni(reset_n), .d_i(mosi),
    .level_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused));

  state_t      state_q, state_d;
  logic [39:0] shadow_q, shadow_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [6:0]  rx_q, rx_d;
  logic        cmd_set_q, cmd_set_d;
  logic [1:0]  cmd_led_q, cmd_led_d;
  logic [1:0]  led_q, led_d;
  logic        miso_q, miso_d;
  logic        done_w, abort_w;
  logic        new_frame;
  logic [39:0] snap;
  logic [7:0]  tx_byte;

  assign snap = jstk_frame(joy_x, joy_y, btn);

  always_comb begin
    tx_byte = PAD_BYTE;
    case (byte_cnt_q)
      BYTE_Y_LO: tx_byte = shadow_q[39:32];
      BYTE_Y_HI: tx_byte = shadow_q[31:24];
      BYTE_X_LO: tx_byte = shadow_q[23:16];
      BYTE_X_HI: tx_byte = shadow_q[15:8];
      BYTE_BTN:  tx_byte = shadow_q[7:0];
      default:   tx_byte = PAD_BYTE;
    endcase
    if (int'(byte_cnt_q) >= FRAME_BYTES) tx_byte = PAD_BYTE;
  end

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    rx_d       = rx_q;
    cmd_set_d  = cmd_set_q;
    cmd_led_d  = cmd_led_q;
    led_d      = led_q;
    miso_d     = miso_q;
    done_w     = 1'b0;
    abort_w    = 1'b0;
    new_frame  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ss_fall) new_frame = 1'b1;
      end
      ST_LOAD: begin
        state_d = ss_rise ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (ss_rise) begin
          state_d = ST_DONE;
        end else if (sclk_rise) begin
          rx_d      = {rx_q[5:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_cnt_d = (byte_cnt_q == 3'd7) ? 3'd7 : byte_cnt_q + 3'd1;
            if (byte_cnt_q == 3'd0) begin
              cmd_set_d = rx_q[JSTK_CMD_LED_BIT-1];
              cmd_led_d = {rx_q[0], mosi_s};
            end
          end
        end else if (sclk_fall) begin
          // counters already reflect the preceding rise, so this is the next bit
          miso_d = tx_byte[~bit_cnt_q];
        end
      end
      ST_DONE: begin
        if (bit_cnt_q == 3'd0 && byte_cnt_q != 3'd0) begin
          done_w = 1'b1;
          if (cmd_set_q) led_d = cmd_led_q;
        end else begin
          abort_w = 1'b1;
        end
        state_d = ST_IDLE;
        if (ss_fall) new_frame = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (new_frame) begin
      state_d    = ST_LOAD;
      shadow_d   = snap;
      miso_d     = snap[39];
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 3'd0;
      rx_d       = 7'd0;
      cmd_set_d  = 1'b0;
      cmd_led_d  = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      shadow_q   <= 40'd0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 3'd0;
      rx_q       <= 7'd0;
      cmd_set_q  <= 1'b0;
      cmd_led_q  <= 2'b00;
      led_q      <= 2'b00;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      rx_q       <= rx_d;
      cmd_set_q  <= cmd_set_d;
      cmd_led_q  <= cmd_led_d;
      led_q      <= led_d;
      miso_q     <= miso_d;
    end
  end

  assign miso        = miso_q;
  assign led         = led_q;
  assign frame_done  = done_w;
  assign frame_abort = abort_w;

`ifdef JSTK_RESP_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  abort_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= 16'd0;
      abort_cnt_q <= 8'd0;
    end else begin
      if (done_w && frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (abort_w && abort_cnt_q != 8'hFF) abort_cnt_q <= abort_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign abort_cnt = abort_cnt_q;
`else
  assign frame_cnt = 16'd0;
  assign abort_cnt = 8'd0;
`endif

endmodule
`default_nettype wire
